// File: rtl/reg_seq_pkg.sv
// Shared encodings for the register move sequencer: ops, FSM states, step counts,
// register indices and the per-step move table.
package reg_seq_pkg;

    typedef enum logic [1:0] {
        OP_SWAP = 2'd0,
        OP_ROTL = 2'd1,
        OP_ROTR = 2'd2,
        OP_COPY = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] STEPS_SWAP = 3'd3;
    localparam logic [2:0] STEPS_ROTL = 3'd5;
    localparam logic [2:0] STEPS_ROTR = 3'd5;
    localparam logic [2:0] STEPS_COPY = 3'd1;

    // Index 4 addresses the temp register on the shared move path.
    localparam logic [2:0] IDX_A = 3'd0;
    localparam logic [2:0] IDX_B = 3'd1;
    localparam logic [2:0] IDX_C = 3'd2;
    localparam logic [2:0] IDX_D = 3'd3;
    localparam logic [2:0] IDX_T = 3'd4;

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
    } move_t;

    function automatic logic [2:0] op_steps(input op_e op);
        logic [2:0] n;
        n = STEPS_COPY;
        case (op)
            OP_SWAP: n = STEPS_SWAP;
            OP_ROTL: n = STEPS_ROTL;
            OP_ROTR: n = STEPS_ROTR;
            default: n = STEPS_COPY;
        endcase
        return n;
    endfunction

    function automatic move_t move_decode(input op_e op, input logic [1:0] src,
                                          input logic [1:0] dst, input logic [2:0] step);
        move_t mv;
        mv.src = {1'b0, src};
        mv.dst = {1'b0, dst};
        case (op)
            OP_SWAP: begin
                case (step)
                    3'd0:    mv = '{src: {1'b0, src}, dst: IDX_T};
                    3'd1:    mv = '{src: {1'b0, dst}, dst: {1'b0, src}};
                    default: mv = '{src: IDX_T, dst: {1'b0, dst}};
                endcase
            end
            OP_ROTL: begin
                case (step)
                    3'd0:    mv = '{src: IDX_A, dst: IDX_T};
                    3'd1:    mv = '{src: IDX_B, dst: IDX_A};
                    3'd2:    mv = '{src: IDX_C, dst: IDX_B};
                    3'd3:    mv = '{src: IDX_D, dst: IDX_C};
                    default: mv = '{src: IDX_T, dst: IDX_D};
                endcase
            end
            OP_ROTR: begin
                case (step)
                    3'd0:    mv = '{src: IDX_D, dst: IDX_T};
                    3'd1:    mv = '{src: IDX_C, dst: IDX_D};
                    3'd2:    mv = '{src: IDX_B, dst: IDX_C};
                    3'd3:    mv = '{src: IDX_A, dst: IDX_B};
                    default: mv = '{src: IDX_T, dst: IDX_A};
                endcase
            end
            default: mv = '{src: {1'b0, src}, dst: {1'b0, dst}};
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/reg_move_sequencer_if.sv
// Command/load handshake and register-bank view between a command source and the sequencer.
interface reg_move_sequencer_if #(parameter int WIDTH = 8);
    logic                 load_valid;
    logic [4*WIDTH-1:0]   load_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_src;
    logic [1:0]           cmd_dst;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [WIDTH-1:0]     d;

    modport master (
        output load_valid, load_data, cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, busy, done, a, b, c, d
    );

    modport slave (
        input  load_valid, load_data, cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, busy, done, a, b, c, d
    );
endinterface

// File: rtl/reg_quad.sv
// Storage for registers a..d plus temp: one indexed write port and a parallel load port.
module reg_quad
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic [4*WIDTH-1:0]   load_data,
    input  logic                 wr_en,
    input  logic [2:0]           wr_idx,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [4*WIDTH-1:0]   bank,
    output logic [WIDTH-1:0]     temp
);

    logic [WIDTH-1:0] temp_reg;

    // Register gi sits in bank slice (3-gi) so that a lands in the MSBs, matching load_data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic [WIDTH-1:0] q_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_reg <= '0;
            end else if (load_en) begin
                q_reg <= load_data[(3-gi)*WIDTH +: WIDTH];
            end else if (wr_en && (wr_idx == 3'(gi))) begin
                q_reg <= wr_data;
            end
        end

        assign bank[(3-gi)*WIDTH +: WIDTH] = q_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_T)) begin
            temp_reg <= wr_data;
        end
    end

    assign temp = temp_reg;

endmodule

// File: rtl/reg_move_sequencer.sv
// Expands swap/rotate/copy commands into one register move per clock over reg_quad.
module reg_move_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_move_sequencer_if.slave  bus
);

    state_e           state_reg, state_next;
    logic [2:0]       step_reg, step_next;
    op_e              op_reg, op_next;
    logic [1:0]       src_reg, src_next;
    logic [1:0]       dst_reg, dst_next;

    logic             cmd_ready;
    logic             load_en;
    logic             wr_en;
    move_t            mv;
    logic [WIDTH-1:0] rd_data;
    logic [4*WIDTH-1:0] bank;
    logic [WIDTH-1:0] temp;

    assign cmd_ready = (state_reg == ST_IDLE) && !bus.load_valid;
    assign load_en   = (state_reg == ST_IDLE) && bus.load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            op_reg    <= OP_SWAP;
            src_reg   <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            op_reg    <= op_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        op_next    = op_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        wr_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_next = ST_MOVE;
                    step_next  = '0;
                    op_next    = op_e'(bus.cmd_op);
                    src_next   = bus.cmd_src;
                    dst_next   = bus.cmd_dst;
                end
            end
            ST_MOVE: begin
                wr_en = 1'b1;
                if (step_reg == op_steps(op_reg) - 3'd1) begin
                    state_next = ST_DONE;
                end else begin
                    step_next = step_reg + 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Single shared move path: decode the current step, read the source, write the destination.
    always_comb begin
        mv = move_decode(op_reg, src_reg, dst_reg, step_reg);
        rd_data = temp;
        case (mv.src)
            IDX_A:   rd_data = bank[4*WIDTH-1 -: WIDTH];
            IDX_B:   rd_data = bank[3*WIDTH-1 -: WIDTH];
            IDX_C:   rd_data = bank[2*WIDTH-1 -: WIDTH];
            IDX_D:   rd_data = bank[WIDTH-1 -: WIDTH];
            default: rd_data = temp;
        endcase
    end

    reg_quad #(.WIDTH(WIDTH)) u_quad (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_data (bus.load_data),
        .wr_en     (wr_en),
        .wr_idx    (mv.dst),
        .wr_data   (rd_data),
        .bank      (bank),
        .temp      (temp)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.a         = bank[4*WIDTH-1 -: WIDTH];
    assign bus.b         = bank[3*WIDTH-1 -: WIDTH];
    assign bus.c         = bank[2*WIDTH-1 -: WIDTH];
    assign bus.d         = bank[WIDTH-1 -: WIDTH];

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Self-checking bench: a move-list model of the register bank checked every cycle,
// plus directed scenarios with hand-computed register values and handshake timing.
module tb_reg_move_sequencer;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    reg_move_sequencer_if #(.WIDTH(8)) bus ();

    reg_move_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- model: registers 0..3 = a..d, index 4 = temp ----------------
    typedef struct {
        int src;
        int dst;
    } mv_t;

    int  m_r [0:4];
    mv_t mq [$];
    bit  m_busy;
    bit  m_done;

    task automatic plan(input int op, input int s, input int d);
        case (op)
            0: begin mq.push_back('{s, 4}); mq.push_back('{d, s}); mq.push_back('{4, d}); end
            1: begin
                mq.push_back('{0, 4}); mq.push_back('{1, 0}); mq.push_back('{2, 1});
                mq.push_back('{3, 2}); mq.push_back('{4, 3});
            end
            2: begin
                mq.push_back('{3, 4}); mq.push_back('{2, 3}); mq.push_back('{1, 2});
                mq.push_back('{0, 1}); mq.push_back('{4, 0});
            end
            default: mq.push_back('{s, d});
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        mv_t mv;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) m_r[i] = 0;
            mq.delete();
            m_busy = 0;
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (mq.size() > 0) begin
            mv = mq.pop_front();
            m_r[mv.dst] = m_r[mv.src];
            if (mq.size() == 0) m_done = 1;
        end else if (bus.load_valid) begin
            for (int i = 0; i < 4; i++) m_r[i] = int'(bus.load_data[(3-i)*8 +: 8]);
        end else if (bus.cmd_valid) begin
            plan(int'(bus.cmd_op), int'(bus.cmd_src), int'(bus.cmd_dst));
            m_busy = 1;
        end
    end

    always @(negedge clk) begin
        check("cyc_a", 32'(bus.a), 32'(m_r[0]));
        check("cyc_b", 32'(bus.b), 32'(m_r[1]));
        check("cyc_c", 32'(bus.c), 32'(m_r[2]));
        check("cyc_d", 32'(bus.d), 32'(m_r[3]));
        check("cyc_busy", 32'(bus.busy), 32'(m_busy));
        check("cyc_done", 32'(bus.done), 32'(m_done));
        check("cyc_ready", 32'(bus.cmd_ready), 32'(!m_busy && !bus.load_valid));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                         output int k);
        bit hs;
        hs = 0;
        k  = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = s;
        bus.cmd_dst   = d;
        #1;
        for (int i = 0; i < 40 && !hs; i++) begin
            hs = bus.cmd_ready;
            tick();
            if (hs) k = cyc;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_src   = ~s;
        bus.cmd_dst   = ~d;
        check("handshake", 32'(hs), 32'd1);
    endtask

    task automatic check_regs(input string name, input int ea, input int eb, input int ec, input int ed);
        check({name, "_a"}, 32'(bus.a), 32'(ea));
        check({name, "_b"}, 32'(bus.b), 32'(eb));
        check({name, "_c"}, 32'(bus.c), 32'(ec));
        check({name, "_d"}, 32'(bus.d), 32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_src    = 2'd0;
        bus.cmd_dst    = 2'd0;

        // Reset state
        tick(); tick();
        check_regs("rst", 0, 0, 0, 0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        $display("txn reset done cyc=%0d", cyc);

        // Load {30,20,15,5}
        bus.load_valid = 1'b1;
        bus.load_data  = {8'd30, 8'd20, 8'd15, 8'd5};
        tick();
        bus.load_valid = 1'b0;
        check_regs("load", 30, 20, 15, 5);
        $display("txn load a=%0d b=%0d c=%0d d=%0d", bus.a, bus.b, bus.c, bus.d);

        // SWAP a<->d
        issue(2'd0, 2'd0, 2'd3, k);
        wait_until(k + 3);
        check_regs("swap", 5, 20, 15, 30);
        check("swap_done_hi", 32'(bus.done), 32'd1);
        check("swap_ready_lo", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("swap_done_lo", 32'(bus.done), 32'd0);
        check("swap_ready_hi", 32'(bus.cmd_ready), 32'd1);
        $display("txn swap 0,3 k=%0d a=%0d d=%0d", k, bus.a, bus.d);

        // Restore {30,20,15,5}, then ROTL and ROTR back-to-back
        bus.load_valid = 1'b1;
        bus.load_data  = {8'd30, 8'd20, 8'd15, 8'd5};
        tick();
        bus.load_valid = 1'b0;
        issue(2'd1, 2'd0, 2'd0, k);
        issue(2'd2, 2'd0, 2'd0, k2);
        check("b2b_period", 32'(k2 - k), 32'd7);
        check_regs("rotl", 20, 15, 5, 30);
        $display("txn rotl k=%0d a=%0d b=%0d c=%0d d=%0d", k, bus.a, bus.b, bus.c, bus.d);
        wait_until(k2 + 5);
        check_regs("rotr", 30, 20, 15, 5);
        check("rotr_done_hi", 32'(bus.done), 32'd1);
        tick();
        check("rotr_done_lo", 32'(bus.done), 32'd0);
        $display("txn rotr k=%0d a=%0d b=%0d c=%0d d=%0d", k2, bus.a, bus.b, bus.c, bus.d);

        // COPY b->c offered together with a load: load wins
        bus.load_valid = 1'b1;
        bus.load_data  = {8'd11, 8'd22, 8'd33, 8'd44};
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'd3;
        bus.cmd_src    = 2'd1;
        bus.cmd_dst    = 2'd2;
        #1;
        check("load_prio_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.load_valid = 1'b0;
        check_regs("load2", 11, 22, 33, 44);
        check("copy_busy_after_load", 32'(bus.busy), 32'd0);
        issue(2'd3, 2'd1, 2'd2, k);
        tick();
        check_regs("copy", 11, 22, 22, 44);
        check("copy_done", 32'(bus.done), 32'd1);
        tick();
        $display("txn copy 1,2 k=%0d c=%0d", k, bus.c);

        // SWAP c<->c with a load attempted mid-move
        issue(2'd0, 2'd2, 2'd2, k);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hFFFF_FFFF;
        tick();
        bus.load_valid = 1'b0;
        wait_until(k + 3);
        check_regs("swap_same", 11, 22, 22, 44);
        check("swap_same_done", 32'(bus.done), 32'd1);
        tick();
        $display("txn swap 2,2 k=%0d a=%0d b=%0d c=%0d d=%0d", k, bus.a, bus.b, bus.c, bus.d);

        // ROTL aborted by reset two edges in
        issue(2'd1, 2'd0, 2'd0, k);
        wait_until(k + 2);
        rst_n = 1'b0;
        #1;
        check_regs("abort", 0, 0, 0, 0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        $display("txn rotl aborted by reset k=%0d", k);

        // Normal operation after reset
        bus.load_valid = 1'b1;
        bus.load_data  = {8'd1, 8'd2, 8'd3, 8'd4};
        tick();
        bus.load_valid = 1'b0;
        issue(2'd3, 2'd0, 2'd3, k);
        tick();
        check_regs("post_rst_copy", 1, 2, 3, 1);
        check("post_rst_done", 32'(bus.done), 32'd1);
        tick(); tick();
        $display("txn copy 0,3 after reset k=%0d d=%0d", k, bus.d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
